// File: rtl/time_counter_if.sv
// Control and time-of-day signals shared between the timekeeper and the watch UI.
// The slave side is the timekeeper; the master side drives enable/load and reads time.
interface time_counter_if;
    logic       count_enable_i;
    logic       load_time_i;
    logic [5:0] load_seconds_i;
    logic [5:0] load_minutes_i;
    logic [4:0] load_hours_i;
    logic [5:0] seconds_o;
    logic [5:0] minutes_o;
    logic [4:0] hours_o;
    logic       tick_1hz_o;
    logic       day_wrap_o;

    modport slave (
        input  count_enable_i,
        input  load_time_i,
        input  load_seconds_i,
        input  load_minutes_i,
        input  load_hours_i,
        output seconds_o,
        output minutes_o,
        output hours_o,
        output tick_1hz_o,
        output day_wrap_o
    );

    modport master (
        output count_enable_i,
        output load_time_i,
        output load_seconds_i,
        output load_minutes_i,
        output load_hours_i,
        input  seconds_o,
        input  minutes_o,
        input  hours_o,
        input  tick_1hz_o,
        input  day_wrap_o
    );
endinterface

// File: rtl/time_counter.sv
// HH:MM:SS timekeeper with a 1 Hz prescaler off the system clock, a load port that
// presets time, and single-cycle pulses for each second and each day rollover.
module time_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic            clk_100MHz_i,
    input  logic            reset_n_i,
    time_counter_if.slave   bus
);
    localparam int PRE_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_FREQ_HZ - 1);

    logic [PRE_W-1:0] prescaler;
    logic [5:0]       seconds;
    logic [5:0]       minutes;
    logic [4:0]       hours;
    logic             tick_1hz;
    logic             day_wrap;

    logic             tick;
    logic             sec_carry;
    logic             min_carry;
    logic             hr_carry;
    logic [5:0]       sec_next;
    logic [5:0]       min_next;
    logic [4:0]       hr_next;
    logic [5:0]       sec_load;
    logic [5:0]       min_load;
    logic [4:0]       hr_load;

    assign tick = bus.count_enable_i && (prescaler == PRE_TC);

    always_comb begin
        sec_carry = (seconds == 6'd59);
        min_carry = sec_carry && (minutes == 6'd59);
        hr_carry  = min_carry && (hours == 5'd23);

        sec_next = sec_carry ? 6'd0 : seconds + 6'd1;
        min_next = minutes;
        hr_next  = hours;
        if (sec_carry) begin
            min_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end
        if (min_carry) begin
            hr_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end
    end

    // Each field is sanitised on its own so one bad field does not discard the others.
    always_comb begin
        sec_load = (bus.load_seconds_i > 6'd59) ? 6'd0 : bus.load_seconds_i;
        min_load = (bus.load_minutes_i > 6'd59) ? 6'd0 : bus.load_minutes_i;
        hr_load  = (bus.load_hours_i   > 5'd23) ? 5'd0 : bus.load_hours_i;
    end

    always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prescaler <= '0;
        end else if (bus.load_time_i || !bus.count_enable_i || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Load wins over a coincident tick; that tick is simply lost.
    always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            seconds  <= 6'd0;
            minutes  <= 6'd0;
            hours    <= 5'd0;
            tick_1hz <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            tick_1hz <= 1'b0;
            day_wrap <= 1'b0;
            if (bus.load_time_i) begin
                seconds <= sec_load;
                minutes <= min_load;
                hours   <= hr_load;
            end else if (tick) begin
                seconds  <= sec_next;
                minutes  <= min_next;
                hours    <= hr_next;
                tick_1hz <= 1'b1;
                day_wrap <= hr_carry;
            end
        end
    end

    assign bus.seconds_o  = seconds;
    assign bus.minutes_o  = minutes;
    assign bus.hours_o    = hours;
    assign bus.tick_1hz_o = tick_1hz;
    assign bus.day_wrap_o = day_wrap;
endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter at CLK_FREQ_HZ=10: seconds-of-day reference model checked
// every cycle, plus hand-computed checkpoints for each scenario.
module tb_time_counter;
    localparam int FREQ = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    bit   chk_en = 1'b0;

    time_counter_if bus();

    time_counter #(.CLK_FREQ_HZ(FREQ)) dut (
        .clk_100MHz_i (clk),
        .reset_n_i    (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time kept as seconds since midnight, prescaler as cycles since last tick.
    int m_tod   = 0;
    int m_phase = 0;
    bit m_tick  = 1'b0;
    bit m_wrap  = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int t, p, s, mi, h;
        bit tk, wr;
        if (!rst_n) begin
            m_tod   <= 0;
            m_phase <= 0;
            m_tick  <= 1'b0;
            m_wrap  <= 1'b0;
        end else begin
            t  = m_tod;
            p  = m_phase;
            tk = 1'b0;
            wr = 1'b0;
            if (bus.load_time_i) begin
                s  = (int'(bus.load_seconds_i) > 59) ? 0 : int'(bus.load_seconds_i);
                mi = (int'(bus.load_minutes_i) > 59) ? 0 : int'(bus.load_minutes_i);
                h  = (int'(bus.load_hours_i)   > 23) ? 0 : int'(bus.load_hours_i);
                t  = h * 3600 + mi * 60 + s;
                p  = 0;
            end else if (!bus.count_enable_i) begin
                p = 0;
            end else begin
                p = p + 1;
                if (p == FREQ) begin
                    p  = 0;
                    t  = (t + 1) % 86400;
                    tk = 1'b1;
                    wr = (t == 0);
                end
            end
            m_tod   <= t;
            m_phase <= p;
            m_tick  <= tk;
            m_wrap  <= wr;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_sec",  int'(bus.seconds_o),  m_tod % 60);
            check("model_min",  int'(bus.minutes_o),  (m_tod / 60) % 60);
            check("model_hr",   int'(bus.hours_o),    m_tod / 3600);
            check("model_tick", int'(bus.tick_1hz_o), int'(m_tick));
            check("model_wrap", int'(bus.day_wrap_o), int'(m_wrap));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_time(input string name, input int h, input int m, input int s,
                               input int tk, input int wr);
        check({name, "_hr"},   int'(bus.hours_o),    h);
        check({name, "_min"},  int'(bus.minutes_o),  m);
        check({name, "_sec"},  int'(bus.seconds_o),  s);
        check({name, "_tick"}, int'(bus.tick_1hz_o), tk);
        check({name, "_wrap"}, int'(bus.day_wrap_o), wr);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus.load_time_i    = 1'b1;
        bus.load_hours_i   = 5'(h);
        bus.load_minutes_i = 6'(m);
        bus.load_seconds_i = 6'(s);
        cyc(1);
        bus.load_time_i    = 1'b0;
    endtask

    initial begin
        bus.count_enable_i = 1'b1;
        bus.load_time_i    = 1'b0;
        bus.load_seconds_i = 6'd0;
        bus.load_minutes_i = 6'd0;
        bus.load_hours_i   = 5'd0;
        chk_en = 1'b1;
        cyc(3);
        expect_time("reset", 0, 0, 0, 0, 0);

        // 1: first tick 10 cycles after release, 00:01:00 after 600
        rst_n = 1'b1;
        cyc(9);
        expect_time("t1_pre", 0, 0, 0, 0, 0);
        cyc(1);
        expect_time("t1_first", 0, 0, 1, 1, 0);
        cyc(590);
        expect_time("t1_600", 0, 1, 0, 1, 0);

        // 2: day rollover
        do_load(23, 59, 59);
        expect_time("t2_load", 23, 59, 59, 0, 0);
        cyc(9);
        expect_time("t2_pre", 23, 59, 59, 0, 0);
        cyc(1);
        expect_time("t2_wrap", 0, 0, 0, 1, 1);
        cyc(1);
        expect_time("t2_after", 0, 0, 0, 0, 0);

        // 3: freeze for 37 cycles mid-count
        cyc(3);
        bus.count_enable_i = 1'b0;
        cyc(37);
        expect_time("t3_frozen", 0, 0, 0, 0, 0);
        bus.count_enable_i = 1'b1;
        cyc(9);
        expect_time("t3_pre", 0, 0, 0, 0, 0);
        cyc(1);
        expect_time("t3_tick", 0, 0, 1, 1, 0);

        // 4: load on the terminal-count cycle drops that tick
        cyc(9);
        do_load(12, 34, 56);
        expect_time("t4_load", 12, 34, 56, 0, 0);
        cyc(9);
        expect_time("t4_pre", 12, 34, 56, 0, 0);
        cyc(1);
        expect_time("t4_tick", 12, 34, 57, 1, 0);

        // 5: out-of-range fields, and load while disabled
        do_load(24, 60, 7);
        expect_time("t5_range", 0, 0, 7, 0, 0);
        do_load(31, 63, 59);
        expect_time("t5_allbad", 0, 0, 59, 0, 0);
        bus.count_enable_i = 1'b0;
        do_load(5, 59, 0);
        expect_time("t5_dis_load", 5, 59, 0, 0, 0);
        cyc(25);
        expect_time("t5_held", 5, 59, 0, 0, 0);
        bus.count_enable_i = 1'b1;

        // 6: asynchronous reset mid-cycle
        do_load(10, 20, 30);
        cyc(3);
        expect_time("t6_before", 10, 20, 30, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        expect_time("t6_async", 0, 0, 0, 0, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(9);
        expect_time("t6_pre", 0, 0, 0, 0, 0);
        cyc(1);
        expect_time("t6_tick", 0, 0, 1, 1, 0);
        cyc(5);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
